// File: rtl/elevator_plant.sv
// elevator_plant: behavioural car/shaft model that closes the loop around the elevator controller.
// Inputs:  clock, reset (async, active-low), motor1 (up), motor2 (down), porta (1 = open door).
// Outputs: sen (one-hot floor sensors or zero), floor (last floor seen), door_closed, door_open,
//          moving (car moved on last step), fault / overtravel (sticky illegal-command flags).
module elevator_plant #(
    parameter int FLOORS          = 4,
    parameter int STEP_TICKS      = 50000000,
    parameter int TICKS_PER_FLOOR = 8,
    parameter int DOOR_STEPS      = 4,
    parameter int START_FLOOR     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              motor1,
    input  logic              motor2,
    input  logic              porta,
    output logic [FLOORS-1:0] sen,
    output logic [2:0]        floor,
    output logic              door_closed,
    output logic              door_open,
    output logic              moving,
    output logic              fault,
    output logic              overtravel
);
    localparam int PMAX = (FLOORS - 1) * TICKS_PER_FLOOR;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int CW   = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
    localparam int DW   = $clog2(DOOR_STEPS + 1);

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_t;

    door_t          state, state_n;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  pos, pos_n;
    logic [DW-1:0]  dc, dc_n;
    logic [2:0]     floor_q;
    logic           tick, up, dn, at_floor;

    assign tick        = cnt == CW'(STEP_TICKS - 1);
    assign door_closed = state == CLOSED;
    assign door_open   = state == OPEN;
    assign up          = motor1 & ~motor2 & door_closed & (pos != PW'(PMAX));
    assign dn          = motor2 & ~motor1 & door_closed & (pos != '0);
    assign pos_n       = up ? pos + 1'b1 : dn ? pos - 1'b1 : pos;
    assign at_floor    = |sen;

    // Sensors and floor are decoded from the registered position only.
    always_comb begin
        sen   = '0;
        floor = floor_q;
        for (int i = 0; i < FLOORS; i++)
            if (pos == PW'(i * TICKS_PER_FLOOR)) begin
                sen[i] = 1'b1;
                floor  = 3'(i);
            end
    end

    // Every door transition takes one step of travel, so entering OPENING/CLOSING
    // already moves dc; a reopen from CLOSING resumes from the current dc.
    always_comb begin
        state_n = state;
        dc_n    = dc;
        case (state)
            CLOSED:
                if (porta && at_floor && !motor1 && !motor2) begin
                    dc_n    = DW'(1);
                    state_n = DOOR_STEPS == 1 ? OPEN : OPENING;
                end
            OPENING:
                if (!porta) state_n = CLOSING;
                else begin
                    dc_n    = dc + 1'b1;
                    state_n = dc_n == DW'(DOOR_STEPS) ? OPEN : OPENING;
                end
            OPEN:
                if (!porta) begin
                    dc_n    = dc - 1'b1;
                    state_n = dc_n == '0 ? CLOSED : CLOSING;
                end
            CLOSING:
                if (porta) begin
                    dc_n    = dc + 1'b1;
                    state_n = dc_n == DW'(DOOR_STEPS) ? OPEN : OPENING;
                end else begin
                    dc_n    = dc - 1'b1;
                    state_n = dc_n == '0 ? CLOSED : CLOSING;
                end
            default: state_n = CLOSED;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            cnt        <= '0;
            pos        <= PW'(START_FLOOR * TICKS_PER_FLOOR);
            floor_q    <= 3'(START_FLOOR);
            state      <= CLOSED;
            dc         <= '0;
            moving     <= 1'b0;
            fault      <= 1'b0;
            overtravel <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            floor_q    <= floor;
            fault      <= fault | (motor1 & motor2) | ((motor1 | motor2) & ~door_closed);
            overtravel <= overtravel | (motor1 & (pos == PW'(PMAX))) | (motor2 & (pos == '0));
            if (tick) begin
                pos    <= pos_n;
                moving <= pos_n != pos;
                state  <= state_n;
                dc     <= dc_n;
            end
        end
endmodule

// File: tb/tb_elevator_plant.sv
// tb_elevator_plant: directed scoreboard bench for elevator_plant (fast-step and prescaled instances).
module tb_elevator_plant;
    logic       clock = 1'b0, reset = 1'b0, motor1 = 1'b0, motor2 = 1'b0, porta = 1'b0;
    logic [3:0] sen;
    logic [2:0] floor;
    logic       dcl, dop, mov, flt, ovt;
    logic       rst_b = 1'b0, m1b = 1'b0;
    logic [2:0] sen_b, floor_b;
    logic       dcl_b, dop_b, mov_b, flt_b, ovt_b;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;

    always #5 clock = ~clock;

    elevator_plant #(.FLOORS(4), .STEP_TICKS(1), .TICKS_PER_FLOOR(4), .DOOR_STEPS(3), .START_FLOOR(0)) dut (
        .clock(clock), .reset(reset), .motor1(motor1), .motor2(motor2), .porta(porta),
        .sen(sen), .floor(floor), .door_closed(dcl), .door_open(dop),
        .moving(mov), .fault(flt), .overtravel(ovt)
    );

    elevator_plant #(.FLOORS(3), .STEP_TICKS(3), .TICKS_PER_FLOOR(2), .DOOR_STEPS(2), .START_FLOOR(1)) dut_b (
        .clock(clock), .reset(rst_b), .motor1(m1b), .motor2(1'b0), .porta(1'b0),
        .sen(sen_b), .floor(floor_b), .door_closed(dcl_b), .door_open(dop_b),
        .moving(mov_b), .fault(flt_b), .overtravel(ovt_b)
    );

    function automatic logic [7:0] observe(int sel);
        case (sel)
            0:  return 8'(sen);
            1:  return 8'(floor);
            2:  return 8'(dcl);
            3:  return 8'(dop);
            4:  return 8'(mov);
            5:  return 8'(flt);
            6:  return 8'(ovt);
            10: return 8'(sen_b);
            11: return 8'(floor_b);
            12: return 8'(dcl_b);
            13: return 8'(dop_b);
            14: return 8'(mov_b);
            15: return 8'(flt_b);
            16: return 8'(ovt_b);
            default: return 8'hxx;
        endcase
    endfunction

    task automatic expect_val(string tag, int sel, logic [7:0] v);
        sb.push_back('{tag, sel, v});
    endtask

    task automatic check();
        exp_t       e;
        logic [7:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            vectors++;
            assert (o === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        step(2);
        expect_val("rst_sen", 0, 8'h1);
        expect_val("rst_floor", 1, 8'h0);
        expect_val("rst_dcl", 2, 8'h1);
        expect_val("rst_dop", 3, 8'h0);
        expect_val("rst_mov", 4, 8'h0);
        expect_val("rst_flt", 5, 8'h0);
        expect_val("rst_ovt", 6, 8'h0);
        check();
        reset = 1'b1;
        motor1 = 1'b1;
        step(1);
        expect_val("up1_sen", 0, 8'h0);
        expect_val("up1_mov", 4, 8'h1);
        expect_val("up1_floor", 1, 8'h0);
        check();
        step(3);
        expect_val("up4_sen", 0, 8'h2);
        expect_val("up4_floor", 1, 8'h1);
        expect_val("up4_mov", 4, 8'h1);
        check();
        step(2);
        expect_val("up6_sen", 0, 8'h0);
        expect_val("up6_floor_hold", 1, 8'h1);
        check();
        step(6);
        expect_val("up12_sen", 0, 8'h8);
        expect_val("up12_floor", 1, 8'h3);
        expect_val("up12_mov", 4, 8'h1);
        expect_val("up12_ovt_not_yet", 6, 8'h0);
        check();
        step(1);
        expect_val("top_sen_hold", 0, 8'h8);
        expect_val("top_mov", 4, 8'h0);
        expect_val("top_ovt", 6, 8'h1);
        expect_val("top_flt", 5, 8'h0);
        check();
        motor1 = 1'b0;
        step(2);
        expect_val("ovt_sticky", 6, 8'h1);
        expect_val("idle_mov", 4, 8'h0);
        check();
        motor2 = 1'b1;
        step(8);
        expect_val("down_sen", 0, 8'h2);
        expect_val("down_floor", 1, 8'h1);
        expect_val("down_mov", 4, 8'h1);
        check();
        motor2 = 1'b0;
        porta = 1'b1;
        step(1);
        expect_val("door1_dcl", 2, 8'h0);
        expect_val("door1_dop", 3, 8'h0);
        expect_val("door1_mov", 4, 8'h0);
        check();
        step(1);
        expect_val("door2_dop", 3, 8'h0);
        check();
        step(1);
        expect_val("door3_dop", 3, 8'h1);
        expect_val("door3_dcl", 2, 8'h0);
        check();
        porta = 1'b0;
        step(1);
        expect_val("rev_dop", 3, 8'h0);
        expect_val("rev_dcl", 2, 8'h0);
        check();
        porta = 1'b1;
        step(1);
        expect_val("reopen_dop", 3, 8'h1);
        check();
        motor1 = 1'b1;
        step(1);
        expect_val("dooropen_sen", 0, 8'h2);
        expect_val("dooropen_mov", 4, 8'h0);
        expect_val("dooropen_flt", 5, 8'h1);
        expect_val("dooropen_dop", 3, 8'h1);
        check();
        motor1 = 1'b0;
        porta = 1'b0;
        step(2);
        expect_val("closing_dcl", 2, 8'h0);
        expect_val("closing_dop", 3, 8'h0);
        check();
        step(1);
        expect_val("closed_dcl", 2, 8'h1);
        check();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        motor1 = 1'b1;
        porta = 1'b1;
        step(1);
        expect_val("prio_sen", 0, 8'h0);
        expect_val("prio_dcl", 2, 8'h1);
        expect_val("prio_mov", 4, 8'h1);
        expect_val("prio_flt", 5, 8'h0);
        check();
        porta = 1'b0;
        step(3);
        expect_val("f1_sen", 0, 8'h2);
        expect_val("f1_floor", 1, 8'h1);
        check();
        motor2 = 1'b1;
        step(1);
        expect_val("both_sen", 0, 8'h2);
        expect_val("both_mov", 4, 8'h0);
        expect_val("both_flt", 5, 8'h1);
        check();
        motor2 = 1'b0;
        step(1);
        expect_val("pos5_sen", 0, 8'h0);
        expect_val("pos5_mov", 4, 8'h1);
        check();
        motor1 = 1'b0;
        porta = 1'b1;
        step(1);
        expect_val("between_dcl", 2, 8'h1);
        expect_val("between_mov", 4, 8'h0);
        expect_val("between_floor", 1, 8'h1);
        check();
        porta = 1'b0;
        motor1 = 1'b1;
        step(1);
        expect_val("pos6_sen", 0, 8'h0);
        expect_val("pos6_mov", 4, 8'h1);
        check();
        #2;
        reset = 1'b0;
        #1;
        expect_val("async_sen", 0, 8'h1);
        expect_val("async_floor", 1, 8'h0);
        expect_val("async_mov", 4, 8'h0);
        expect_val("async_flt", 5, 8'h0);
        expect_val("async_ovt", 6, 8'h0);
        expect_val("async_dcl", 2, 8'h1);
        check();
        reset = 1'b1;
        step(1);
        expect_val("resume_sen", 0, 8'h0);
        expect_val("resume_mov", 4, 8'h1);
        check();
        expect_val("b_rst_sen", 10, 8'h2);
        expect_val("b_rst_floor", 11, 8'h1);
        expect_val("b_rst_dcl", 12, 8'h1);
        expect_val("b_rst_mov", 14, 8'h0);
        check();
        rst_b = 1'b1;
        m1b = 1'b1;
        step(2);
        expect_val("b_pre_sen", 10, 8'h2);
        expect_val("b_pre_mov", 14, 8'h0);
        check();
        step(1);
        expect_val("b_tick1_sen", 10, 8'h0);
        expect_val("b_tick1_mov", 14, 8'h1);
        expect_val("b_tick1_floor", 11, 8'h1);
        check();
        step(2);
        expect_val("b_hold_mov", 14, 8'h1);
        expect_val("b_hold_sen", 10, 8'h0);
        check();
        step(1);
        expect_val("b_tick2_sen", 10, 8'h4);
        expect_val("b_tick2_floor", 11, 8'h2);
        expect_val("b_tick2_ovt", 16, 8'h0);
        check();
        step(1);
        expect_val("b_ovt_every_clk", 16, 8'h1);
        expect_val("b_ovt_sen", 10, 8'h4);
        expect_val("b_ovt_flt", 15, 8'h0);
        check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
